// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - binary-to-BCD seven-segment scan driver with multiplexed anodes
// Optional leading-zero blanking is enabled by defining SSD_LZ_BLANK_EN.
module ssd_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int DATA_W      = 14,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        seg_out
);

    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
    localparam logic [6:0]       SEG_DASH  = 7'b0111111;

    function automatic logic [63:0] max_disp(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_disp(DIGITS);

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = SEG_BLANK;
        endcase
    endfunction

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  bin;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   bit_cnt;
    logic               ovf;
    logic [BCD_W-1:0]   disp;
    logic               disp_ovf;

    logic [REF_W-1:0]   ref_cnt;
    logic [IDX_W-1:0]   digit_idx;
    logic [DIGITS-1:0]  blank;
    logic [DIGITS-1:0]  anode_nxt;
    logic [6:0]         seg_nxt;
    logic [3:0]         cur_nib;
    logic               cur_blank;

    // Double-dabble correction: nibbles of 5 or more get +3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            bin      <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            ovf      <= 1'b0;
            disp     <= '0;
            disp_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin     <= value;
                        bcd     <= '0;
                        bit_cnt <= CNT_W'(DATA_W);
                        ovf     <= (64'(value) > MAX_VAL);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt != '0) begin
                        bcd     <= {bcd_adj[BCD_W-2:0], bin[DATA_W-1]};
                        bin     <= bin << 1;
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end else begin
                        // All digits commit together so the scan never shows a half-converted value.
                        disp     <= bcd;
                        disp_ovf <= ovf;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        blank = '0;
`ifdef SSD_LZ_BLANK_EN
        begin
            logic upper_zero;
            upper_zero = 1'b1;
            for (int i = DIGITS - 1; i > 0; i--) begin
                upper_zero = upper_zero & (disp[i*4 +: 4] == 4'd0);
                blank[i]   = upper_zero;
            end
        end
`endif
    end

    always_comb begin
        cur_nib   = 4'd0;
        cur_blank = 1'b0;
        anode_nxt = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == digit_idx) begin
                cur_nib      = disp[i*4 +: 4];
                cur_blank    = blank[i];
                anode_nxt[i] = 1'b0;
            end
        end
        if (disp_ovf) begin
            seg_nxt = SEG_DASH;
        end else if (cur_blank) begin
            seg_nxt = SEG_BLANK;
        end else begin
            seg_nxt = decode(cur_nib);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ref_cnt   <= '0;
            digit_idx <= '0;
            anode     <= '1;
            seg_out   <= SEG_BLANK;
        end else begin
            if (ref_cnt == REF_LAST) begin
                ref_cnt   <= '0;
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
            end else begin
                ref_cnt <= ref_cnt + REF_W'(1);
            end
            anode   <= anode_nxt;
            seg_out <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - self-checking bench for ssd_scan_driver
module tb_ssd_scan_driver;

    localparam int DIGITS      = 4;
    localparam int DATA_W      = 14;
    localparam int REFRESH_DIV = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              load = 1'b0;
    logic [DATA_W-1:0] value = '0;
    logic              busy;
    logic [DIGITS-1:0] anode;
    logic [6:0]        seg_out;

    int errors = 0;
    int checks = 0;
    logic [6:0] got_seg [DIGITS];

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .DIGITS(DIGITS),
        .DATA_W(DATA_W),
        .REFRESH_DIV(REFRESH_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .value(value),
        .busy(busy),
        .anode(anode),
        .seg_out(seg_out)
    );

    function automatic logic [6:0] exp_seg(input int v, input int i);
        int p;
        p = 1;
        for (int j = 0; j < i; j++) p = p * 10;
        if (v > 9999) return 7'b0111111;
`ifdef SSD_LZ_BLANK_EN
        if (i > 0 && v < p) return 7'b1111111;
`endif
        case ((v / p) % 10)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [DIGITS-1:0] exp_anode(input int idx);
        logic [DIGITS-1:0] a;
        a = '1;
        a[idx] = 1'b0;
        return a;
    endfunction

    task automatic check_display(input int v, input string name);
        for (int i = 0; i < DIGITS; i++) got_seg[i] = 7'bxxxxxxx;
        for (int c = 0; c < 2 * DIGITS * REFRESH_DIV; c++) begin
            @(negedge clk);
            for (int i = 0; i < DIGITS; i++) begin
                if (anode == exp_anode(i)) got_seg[i] = seg_out;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            checks++;
            if (got_seg[i] !== exp_seg(v, i)) begin
                errors++;
                $display("FAIL %s digit%0d: got %b expected %b", name, i, got_seg[i], exp_seg(v, i));
            end
        end
    endtask

    // Call on a negedge; returns on the negedge where busy is first seen low.
    task automatic load_and_check(input int v, input int extra_at, input int extra_v, input string name);
        int cnt;
        load  = 1'b1;
        value = DATA_W'(v);
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_rise: got %b expected 1", name, busy);
        end
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (cnt == extra_at) begin
                load  = 1'b1;
                value = DATA_W'(extra_v);
            end else if (cnt == extra_at + 1) begin
                load = 1'b0;
            end
        end
        load = 1'b0;
        checks++;
        if (cnt != DATA_W + 1) begin
            errors++;
            $display("FAIL %s busy_len: got %0d edges expected %0d", name, cnt, DATA_W + 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (anode !== 4'b1111 || seg_out !== 7'h7F || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got anode=%b seg=%b busy=%b expected 1111 1111111 0", anode, seg_out, busy);
        end
        rst = 1'b1;
        for (int k = 0; k < 4 * DIGITS * REFRESH_DIV / 2; k++) begin
            @(negedge clk);
            checks++;
            if (anode !== exp_anode((k / REFRESH_DIV) % DIGITS) ||
                seg_out !== exp_seg(0, (k / REFRESH_DIV) % DIGITS)) begin
                errors++;
                $display("FAIL scan_step%0d: got anode=%b seg=%b expected anode=%b seg=%b", k, anode, seg_out,
                         exp_anode((k / REFRESH_DIV) % DIGITS), exp_seg(0, (k / REFRESH_DIV) % DIGITS));
            end
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        load_and_check(1234, -5, 0, "load1234");
        check_display(1234, "disp1234");
    endtask

    task automatic test_overflow();
        @(negedge clk);
        load_and_check(12000, -5, 0, "load12000");
        check_display(12000, "disp12000");
        @(negedge clk);
        load_and_check(9999, -5, 0, "load9999");
        check_display(9999, "disp9999");
    endtask

    task automatic test_load_while_busy();
        @(negedge clk);
        load_and_check(5, 3, 7, "load5");
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_load_busy: got %b expected 0", busy);
        end
        check_display(5, "disp5");
    endtask

    task automatic test_reset_mid_conversion();
        int cnt;
        @(negedge clk);
        load  = 1'b1;
        value = DATA_W'(1234);
        @(negedge clk);
        load = 1'b0;
        cnt = 0;
        while (cnt < 6) begin
            @(negedge clk);
            cnt++;
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (busy !== 1'b0 || anode !== 4'b1111) begin
            errors++;
            $display("FAIL abort_reset: got busy=%b anode=%b expected 0 1111", busy, anode);
        end
        check_display(0, "disp_abort");
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy_late: got %b expected 0", busy);
        end
        check_display(0, "disp_abort_late");
    endtask

    task automatic test_lz();
        @(negedge clk);
        load_and_check(42, -5, 0, "load42");
        check_display(42, "disp42");
        @(negedge clk);
        load_and_check(0, -5, 0, "load0");
        check_display(0, "disp0");
    endtask

    task automatic test_random();
        int v;
        for (int n = 0; n < 8; n++) begin
            v = (n % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
            @(negedge clk);
            load_and_check(v, -5, 0, $sformatf("rand_load%0d", n));
            check_display(v, $sformatf("rand_disp%0d", n));
        end
    endtask

    task automatic test_back_to_back();
        int a;
        int b;
        a = int'($urandom_range(0, 9999));
        b = int'($urandom_range(0, 9999));
        @(negedge clk);
        load_and_check(a, -5, 0, "b2b_first");
        load_and_check(b, -5, 0, "b2b_second");
        check_display(b, "b2b_disp");
        load_and_check(16383, -5, 0, "b2b_max");
        check_display(16383, "b2b_max_disp");
        load_and_check(10000, -5, 0, "b2b_edge");
        check_display(10000, "b2b_edge_disp");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_load_while_busy();
        test_reset_mid_conversion();
        test_lz();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
